// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared types and constants for the forwarding / scoreboard
//                unit (operand source select, stage record, x0 index).
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Default configuration widths; the modules themselves stay parametric.
  localparam int unsigned c_XLEN_DEF  = 32;
  localparam int unsigned c_NREGS_DEF = 32;
  localparam int unsigned c_RW_DEF    = $clog2(c_NREGS_DEF);

  // Architectural zero register: never a hazard, never tracked.
  localparam int unsigned c_X0 = 0;

  typedef logic [c_RW_DEF-1:0] reg_idx_t;

  // Where a resolved operand comes from.
  typedef enum logic [1:0] {
    SRC_RF    = 2'd0,
    SRC_STAGE = 2'd1,
    SRC_LLWB  = 2'd2
  } fwd_src_e;

  // One in-flight pipeline stage as seen by the forwarding network.
  typedef struct packed {
    logic                  valid;
    reg_idx_t              rd;
    logic [c_XLEN_DEF-1:0] data;
    logic                  rdy;
  } fwd_stage_t;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_port_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_port_resolve
//  Description : Operand resolution for a single register read port:
//                stage forwarding (youngest wins), same-cycle long-latency
//                writeback bypass, scoreboard check, register-file fallback.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_port_resolve
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RW      = 5,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [RW-1:0]                 i_rs,
  input  logic                          i_used,
  input  logic [XLEN-1:0]               i_rf_data,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [NUM_FWD-1:0][RW-1:0]    i_fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]  i_fwd_data,
  input  logic [NUM_FWD-1:0]            i_fwd_rdy,
  input  logic                          i_wb_valid,
  input  logic [RW-1:0]                 i_wb_rd,
  input  logic [XLEN-1:0]               i_wb_data,
  input  logic                          i_pend_nz,
  output logic [XLEN-1:0]               o_data,
  output logic                          o_hazard
);

  fwd_src_e        w_src;
  logic            w_hit;
  logic            w_hit_rdy;
  logic [XLEN-1:0] w_hit_data;

  // Pick the operand source; scanning oldest-to-youngest lets the youngest match overwrite.
  always_comb begin
    w_src      = SRC_RF;
    w_hit      = 1'b0;
    w_hit_rdy  = 1'b0;
    w_hit_data = '0;
    o_hazard   = 1'b0;
    if (i_used && (i_rs != RW'(c_X0))) begin
      for (int s = NUM_FWD - 1; s >= 0; s--) begin
        if (i_fwd_valid[s] && (i_fwd_rd[s] == i_rs)) begin
          w_hit      = 1'b1;
          w_hit_rdy  = i_fwd_rdy[s];
          w_hit_data = i_fwd_data[s];
        end
      end
      if (w_hit) begin
        if (w_hit_rdy) w_src = SRC_STAGE;
        else           o_hazard = 1'b1;   // load-use: older stages must not be used
      end else if (i_wb_valid && (i_wb_rd == i_rs)) begin
        w_src = SRC_LLWB;
      end else if (i_pend_nz) begin
        o_hazard = 1'b1;
      end
    end
  end

  // Operand mux driven by the selected source.
  always_comb begin
    case (w_src)
      SRC_STAGE: o_data = w_hit_data;
      SRC_LLWB:  o_data = i_wb_data;
      default:   o_data = i_rf_data;
    endcase
  end

endmodule : fwd_port_resolve
`default_nettype wire

// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_unit
//  Description : Multi-port operand forwarding with a per-register pending
//                write scoreboard for long-latency producers, stall
//                generation and a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned NREGS   = 32,
  parameter  int unsigned NUM_RS  = 2,
  parameter  int unsigned NUM_FWD = 2,
  parameter  int unsigned PEND_W  = 2,
  localparam int unsigned RW      = $clog2(NREGS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic [NUM_FWD-1:0][RW-1:0]    fwd_rd_i,
  input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data_i,
  input  logic [NUM_FWD-1:0]            fwd_rdy_i,
  input  logic [NUM_RS-1:0][RW-1:0]     rs_i,
  input  logic [NUM_RS-1:0]             rs_used_i,
  input  logic [NUM_RS-1:0][XLEN-1:0]   rs_data_i,
  output logic [NUM_RS-1:0][XLEN-1:0]   rs_data_ao,
  output logic                          stall_ao,
  input  logic                          ll_issue_valid_i,
  input  logic [RW-1:0]                 ll_issue_rd_i,
  output logic                          ll_issue_ready_o,
  input  logic                          ll_wb_valid_i,
  input  logic [RW-1:0]                 ll_wb_rd_i,
  input  logic [XLEN-1:0]               ll_wb_data_i,
  output logic                          sb_err_o,
  output logic [31:0]                   stall_cnt_o
);

  logic [PEND_W-1:0] r_pend      [NREGS];
  logic [PEND_W-1:0] w_pend_next [NREGS];
  logic              r_sb_err;
  logic [31:0]       r_stall_cnt;

  logic [NUM_RS-1:0] w_hazard;
  logic [NUM_RS-1:0] w_pend_nz;
  logic              w_inc;
  logic              w_dec;
  logic              w_same;
  logic              w_err_set;

  generate
    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
      assign w_pend_nz[p] = (r_pend[rs_i[p]] != '0);

      fwd_port_resolve #(
        .XLEN    (XLEN),
        .RW      (RW),
        .NUM_FWD (NUM_FWD)
      ) u_resolve (
        .i_rs        (rs_i[p]),
        .i_used      (rs_used_i[p]),
        .i_rf_data   (rs_data_i[p]),
        .i_fwd_valid (fwd_valid_i),
        .i_fwd_rd    (fwd_rd_i),
        .i_fwd_data  (fwd_data_i),
        .i_fwd_rdy   (fwd_rdy_i),
        .i_wb_valid  (ll_wb_valid_i),
        .i_wb_rd     (ll_wb_rd_i),
        .i_wb_data   (ll_wb_data_i),
        .i_pend_nz   (w_pend_nz[p]),
        .o_data      (rs_data_ao[p]),
        .o_hazard    (w_hazard[p])
      );
    end
  endgenerate

  // A saturated destination counter blocks the issue by stalling decode.
  assign ll_issue_ready_o = (r_pend[ll_issue_rd_i] != {PEND_W{1'b1}});
  assign stall_ao         = (|w_hazard) | (ll_issue_valid_i & ~ll_issue_ready_o);

  assign w_inc  = ll_issue_valid_i & ~stall_ao & (ll_issue_rd_i != RW'(c_X0));
  assign w_dec  = ll_wb_valid_i & (ll_wb_rd_i != RW'(c_X0));
  assign w_same = w_inc & w_dec & (ll_issue_rd_i == ll_wb_rd_i);

  // Next scoreboard state: an issue and a writeback to one register cancel out.
  always_comb begin
    w_pend_next = r_pend;
    w_err_set   = 1'b0;
    if (w_inc && !w_same) begin
      w_pend_next[ll_issue_rd_i] = r_pend[ll_issue_rd_i] + 1'b1;
    end
    if (w_dec && !w_same) begin
      if (r_pend[ll_wb_rd_i] == '0) w_err_set = 1'b1;
      else w_pend_next[ll_wb_rd_i] = r_pend[ll_wb_rd_i] - 1'b1;
    end
  end

  // Scoreboard, sticky error and saturating stall counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
      r_sb_err    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_pend <= w_pend_next;
      if (w_err_set) r_sb_err <= 1'b1;
      if (stall_ao && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sb_err_o    = r_sb_err;
  assign stall_cnt_o = r_stall_cnt;

endmodule : fwd_scoreboard_unit
`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_scoreboard_unit
//  Description : Self-checking bench for fwd_scoreboard_unit: directed
//                scenarios plus random traffic against a behavioural model,
//                expectations queued by the driver and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard_unit;

  localparam int XLEN = 32, NREGS = 32, RW = 5, NUM_RS = 2, NUM_FWD = 2, PEND_W = 2;
  localparam int PMAX = (1 << PEND_W) - 1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // DUT-facing inputs (updated only at the falling edge by step())
  logic [NUM_FWD-1:0]            fwd_valid, s_fwd_valid;
  logic [NUM_FWD-1:0][RW-1:0]    fwd_rd,    s_fwd_rd;
  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,  s_fwd_data;
  logic [NUM_FWD-1:0]            fwd_rdy,   s_fwd_rdy;
  logic [NUM_RS-1:0][RW-1:0]     rs,        s_rs;
  logic [NUM_RS-1:0]             rs_used,   s_rs_used;
  logic [NUM_RS-1:0][XLEN-1:0]   rs_data,   s_rs_data;
  logic                          iss_v,     s_iss_v;
  logic [RW-1:0]                 iss_rd,    s_iss_rd;
  logic                          wb_v,      s_wb_v;
  logic [RW-1:0]                 wb_rd,     s_wb_rd;
  logic [XLEN-1:0]               wb_data,   s_wb_data;

  logic [NUM_RS-1:0][XLEN-1:0]   rs_data_ao;
  logic                          stall_ao, ll_issue_ready_o, sb_err_o;
  logic [31:0]                   stall_cnt_o;

  fwd_scoreboard_unit #(
    .XLEN(XLEN), .NREGS(NREGS), .NUM_RS(NUM_RS), .NUM_FWD(NUM_FWD), .PEND_W(PEND_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fwd_valid_i      (fwd_valid),
    .fwd_rd_i         (fwd_rd),
    .fwd_data_i       (fwd_data),
    .fwd_rdy_i        (fwd_rdy),
    .rs_i             (rs),
    .rs_used_i        (rs_used),
    .rs_data_i        (rs_data),
    .rs_data_ao       (rs_data_ao),
    .stall_ao         (stall_ao),
    .ll_issue_valid_i (iss_v),
    .ll_issue_rd_i    (iss_rd),
    .ll_issue_ready_o (ll_issue_ready_o),
    .ll_wb_valid_i    (wb_v),
    .ll_wb_rd_i       (wb_rd),
    .ll_wb_data_i     (wb_data),
    .sb_err_o         (sb_err_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  typedef struct {
    logic [NUM_RS-1:0][XLEN-1:0] data;
    logic [NUM_RS-1:0]           chk;
    logic                        stall;
    logic                        ready;
    logic                        err;
    logic [31:0]                 cnt;
  } exp_t;

  exp_t        q[$];
  int          pend_m[NREGS];
  bit          err_m;
  logic [31:0] cnt_m;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one read port resolved from the forwarding rules
  function automatic void resolve(input int p, output logic [XLEN-1:0] d, output bit haz);
    bit found = 0;
    haz = 0;
    d   = rs_data[p];
    if (!rs_used[p] || rs[p] == 0) return;
    for (int s = 0; s < NUM_FWD; s++) begin
      if (!found && fwd_valid[s] && fwd_rd[s] == rs[p]) begin
        found = 1;
        if (fwd_rdy[s]) d = fwd_data[s];
        else            haz = 1;
      end
    end
    if (!found) begin
      if (wb_v && wb_rd == rs[p]) d = wb_data;
      else if (pend_m[rs[p]] != 0) haz = 1;
    end
  endfunction

  task automatic idle();
    s_fwd_valid = '0; s_fwd_rd = '0; s_fwd_data = '0; s_fwd_rdy = '0;
    s_rs = '0; s_rs_used = '0;
    for (int p = 0; p < NUM_RS; p++) s_rs_data[p] = $urandom;
    s_iss_v = 0; s_iss_rd = '0; s_wb_v = 0; s_wb_rd = '0; s_wb_data = $urandom;
  endtask

  // Apply staged inputs for one cycle, queue expectations, advance the model
  task automatic step();
    exp_t e;
    logic [XLEN-1:0] d;
    bit haz, any, inc, dec;
    @(negedge clk_i);
    fwd_valid = s_fwd_valid; fwd_rd = s_fwd_rd; fwd_data = s_fwd_data; fwd_rdy = s_fwd_rdy;
    rs = s_rs; rs_used = s_rs_used; rs_data = s_rs_data;
    iss_v = s_iss_v; iss_rd = s_iss_rd; wb_v = s_wb_v; wb_rd = s_wb_rd; wb_data = s_wb_data;
    #1;
    any = 0;
    for (int p = 0; p < NUM_RS; p++) begin
      resolve(p, d, haz);
      e.data[p] = d;
      e.chk[p]  = !haz;
      any |= haz;
    end
    e.ready = (pend_m[iss_rd] != PMAX);
    e.stall = any || (iss_v && !e.ready);
    e.err   = err_m;
    e.cnt   = cnt_m;
    q.push_back(e);
    inc = iss_v && !e.stall && iss_rd != 0;
    dec = wb_v && wb_rd != 0;
    if (!(inc && dec && iss_rd == wb_rd)) begin
      if (inc) pend_m[iss_rd]++;
      if (dec) begin
        if (pend_m[wb_rd] == 0) err_m = 1;
        else pend_m[wb_rd]--;
      end
    end
    if (e.stall && cnt_m != 32'hFFFF_FFFF) cnt_m++;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) pend_m[r] = 0;
    err_m = 0;
    cnt_m = '0;
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < NUM_RS; p++)
          if (e.chk[p]) cmp($sformatf("rs_data_ao[%0d]", p), rs_data_ao[p], e.data[p]);
        cmp("stall_ao", {31'b0, stall_ao}, {31'b0, e.stall});
        cmp("ll_issue_ready_o", {31'b0, ll_issue_ready_o}, {31'b0, e.ready});
        cmp("sb_err_o", {31'b0, sb_err_o}, {31'b0, e.err});
        cmp("stall_cnt_o", stall_cnt_o, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0; fwd_rdy = '0;
    rs = '0; rs_used = '0; rs_data = '0;
    iss_v = 0; iss_rd = '0; wb_v = 0; wb_rd = '0; wb_data = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    idle(); step(); #2;
    cmp("reset_stall_cnt", stall_cnt_o, 32'd0);
    cmp("reset_sb_err", {31'b0, sb_err_o}, 32'd0);

    // Youngest matching stage wins
    idle();
    s_rs[0] = 5; s_rs_used[0] = 1;
    s_fwd_valid = 2'b11; s_fwd_rdy = 2'b11;
    s_fwd_rd[0] = 5; s_fwd_data[0] = 32'hAAAA;
    s_fwd_rd[1] = 5; s_fwd_data[1] = 32'hBBBB;
    step(); #2;
    cmp("prio_data", rs_data_ao[0], 32'hAAAA);
    cmp("prio_stall", {31'b0, stall_ao}, 32'd0);

    // Load-use hazard, then the same with the operand unused
    idle();
    s_fwd_valid[0] = 1; s_fwd_rd[0] = 7; s_fwd_rdy[0] = 0;
    s_rs[1] = 7; s_rs_used[1] = 1;
    step(); #2;
    cmp("loaduse_stall", {31'b0, stall_ao}, 32'd1);
    s_rs_used[1] = 0;
    step(); #2;
    cmp("unused_stall", {31'b0, stall_ao}, 32'd0);
    cmp("unused_data", rs_data_ao[1], s_rs_data[1]);

    // Scoreboard: issue, stall on read, same-cycle writeback bypass, cleared
    idle(); s_iss_v = 1; s_iss_rd = 9; step();
    idle(); s_rs[0] = 9; s_rs_used[0] = 1; step(); #2;
    cmp("sb_pending_stall", {31'b0, stall_ao}, 32'd1);
    step();
    s_wb_v = 1; s_wb_rd = 9; s_wb_data = 32'h1234; step(); #2;
    cmp("sb_bypass_data", rs_data_ao[0], 32'h1234);
    cmp("sb_bypass_stall", {31'b0, stall_ao}, 32'd0);
    s_wb_v = 0; step(); #2;
    cmp("sb_cleared_stall", {31'b0, stall_ao}, 32'd0);

    // Counter saturation
    idle(); s_iss_v = 1; s_iss_rd = 3;
    repeat (3) step();
    s_iss_v = 0; step(); #2;
    cmp("sat_ready", {31'b0, ll_issue_ready_o}, 32'd0);
    s_iss_v = 1; step(); #2;
    cmp("sat_issue_stall", {31'b0, stall_ao}, 32'd1);
    idle(); s_rs[1] = 3; s_rs_used[1] = 1; s_iss_rd = 3; step();
    idle(); s_wb_v = 1; s_wb_rd = 3; step();
    s_iss_v = 1; s_iss_rd = 3; step();
    idle(); s_iss_rd = 3; s_rs[0] = 3; s_rs_used[0] = 1; step(); #2;
    cmp("sat_inc_dec_ready", {31'b0, ll_issue_ready_o}, 32'd1);
    idle(); s_wb_v = 1; s_wb_rd = 3; repeat (2) step();
    idle(); s_rs[0] = 3; s_rs_used[0] = 1; step(); #2;
    cmp("sat_drained_stall", {31'b0, stall_ao}, 32'd0);

    // Writeback to an idle register sets a sticky error; x0 is never tracked
    idle(); s_wb_v = 1; s_wb_rd = 4; step();
    idle(); step(); #2;
    cmp("err_set", {31'b0, sb_err_o}, 32'd1);
    s_iss_v = 1; s_iss_rd = 0; step();
    idle();
    s_fwd_valid[0] = 1; s_fwd_rd[0] = 0; s_fwd_rdy[0] = 0;
    s_rs[0] = 0; s_rs_used[0] = 1; step(); #2;
    cmp("x0_no_stall", {31'b0, stall_ao}, 32'd0);
    cmp("err_held", {31'b0, sb_err_o}, 32'd1);

    // Async reset in the middle of a scoreboard stall
    idle(); s_iss_v = 1; s_iss_rd = 10; step();
    idle(); s_rs[0] = 10; s_rs_used[0] = 1; s_iss_rd = 10; step(); #2;
    cmp("pre_reset_stall", {31'b0, stall_ao}, 32'd1);
    rst_ni = 1'b0;
    #1;
    model_reset();
    cmp("async_rst_stall", {31'b0, stall_ao}, 32'd0);
    cmp("async_rst_cnt", stall_cnt_o, 32'd0);
    cmp("async_rst_err", {31'b0, sb_err_o}, 32'd0);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // Random traffic over a small register window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int s = 0; s < NUM_FWD; s++) begin
        s_fwd_valid[s] = ($urandom_range(0, 1) == 1);
        s_fwd_rd[s]    = RW'($urandom_range(0, 7));
        s_fwd_data[s]  = $urandom;
        s_fwd_rdy[s]   = ($urandom_range(0, 3) != 0);
      end
      for (int p = 0; p < NUM_RS; p++) begin
        s_rs[p]      = RW'($urandom_range(0, 7));
        s_rs_used[p] = ($urandom_range(0, 3) != 0);
      end
      s_iss_v  = ($urandom_range(0, 2) == 0);
      s_iss_rd = RW'($urandom_range(0, 7));
      s_wb_v   = ($urandom_range(0, 2) == 0);
      s_wb_rd  = RW'($urandom_range(0, 7));
      step();
    end

    idle(); step();
    repeat (2) @(negedge clk_i);
    #3;
    cmp("queue_drain", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fwd_scoreboard_unit
`default_nettype wire
